timing_sequencer: RTL and testbench

- Control-unit timing generator for the basic computer: a sequence counter (SC) with a start/stop flip-flop (S), decoded to one-hot timing signals T0..T(2**SC_WIDTH-1).
- Also holds the instruction opcode field and decodes it to one-hot D0..D(2**OP_WIDTH-1).
- Performs the decode direction of the one-hot encoding used elsewhere in the datapath.
- Feeds the control-logic gates that combine T and D terms.

---
 rtl/timing_sequencer_if.sv | 39 +++
 rtl/timing_sequencer.sv | 112 +++++++++++
 tb/tb_timing_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/timing_sequencer_if.sv
// -----------------------------------------------------------------------------
// timing_sequencer_if
// Purpose : groups the control strobes, the opcode field and the decoded
//           timing/opcode outputs of the control-unit timing sequencer.
// Signals : start, halt, sc_clr, sc_inc, op_load, op_in  -> into the sequencer
//           sc_value, running, t_out, d_out, wrap         <- from the sequencer
// Modports: master (the controller/bench driving strobes), slave (sequencer).
//
// Strobe protocol: every input is a level sampled on each rising clk edge;
// there is no valid/ready pairing because the sequencer accepts every
// command on the edge it is seen. A strobe held for N cycles acts N times.
// Outputs are pure functions of registered state, valid the whole cycle.
// -----------------------------------------------------------------------------
interface timing_sequencer_if #(
  parameter int SC_WIDTH = 4,
  parameter int OP_WIDTH = 3
);
  logic                     start;
  logic                     halt;
  logic                     sc_clr;
  logic                     sc_inc;
  logic                     op_load;
  logic [OP_WIDTH-1:0]      op_in;
  logic [SC_WIDTH-1:0]      sc_value;
  logic                     running;
  logic [(1<<SC_WIDTH)-1:0] t_out;
  logic [(1<<OP_WIDTH)-1:0] d_out;
  logic                     wrap;

  modport master (
    output start, halt, sc_clr, sc_inc, op_load, op_in,
    input  sc_value, running, t_out, d_out, wrap
  );

  modport slave (
    input  start, halt, sc_clr, sc_inc, op_load, op_in,
    output sc_value, running, t_out, d_out, wrap
  );
endinterface

// File: rtl/timing_sequencer.sv
// -----------------------------------------------------------------------------
// timing_sequencer
// Purpose : basic-computer control timing. A sequence counter (SC) gated by a
//           start/stop flip-flop (S) is decoded to one-hot T0..T(2**SC_WIDTH-1);
//           an opcode register is decoded to one-hot D0..D(2**OP_WIDTH-1).
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - timing_sequencer_if.slave (strobes in, decodes out)
// The S flip-flop is the only FSM; its state is visible on bus.running.
// -----------------------------------------------------------------------------
module timing_sequencer #(
  parameter int SC_WIDTH = 4,
  parameter int OP_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  timing_sequencer_if.slave  bus
);

  localparam int T_WIDTH = 1 << SC_WIDTH;
  localparam int D_WIDTH = 1 << OP_WIDTH;
  localparam logic [SC_WIDTH-1:0] SC_MAX = {SC_WIDTH{1'b1}};
  localparam logic [SC_WIDTH-1:0] SC_ONE = {{(SC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } seq_state_t;

  seq_state_t          state_q, state_d;
  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic                wrap_q, wrap_d;
  logic [OP_WIDTH-1:0] op_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOPPED;
      sc_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      wrap_q  <= wrap_d;
    end
  end

  // Opcode register is independent of the sequencer; guarded so an
  // undriven op_in never reaches the register unless loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (bus.op_load) begin
      op_q <= bus.op_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // Priority: halt > start > (running: sc_clr > sc_inc) > hold.
  // halt freezes SC even when start is also high.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    wrap_d  = 1'b0;

    if (bus.halt) begin
      state_d = ST_STOPPED;
    end else if (bus.start) begin
      state_d = ST_RUNNING;
      sc_d    = '0;
    end else if (state_q == ST_RUNNING) begin
      if (bus.sc_clr) begin
        // Clearing from max is not a wrap.
        sc_d = '0;
      end else if (bus.sc_inc) begin
        sc_d   = sc_q + SC_ONE;
        wrap_d = (sc_q == SC_MAX);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decoders: combinational from registered state only.
  // ---------------------------------------------------------------------------
  logic [T_WIDTH-1:0] t_dec;
  logic [D_WIDTH-1:0] d_dec;

  always_comb begin
    t_dec = '0;
    for (int i = 0; i < T_WIDTH; i++) begin
      t_dec[i] = (state_q == ST_RUNNING) && (sc_q == SC_WIDTH'(i));
    end
  end

  always_comb begin
    d_dec = '0;
    for (int j = 0; j < D_WIDTH; j++) begin
      d_dec[j] = (op_q == OP_WIDTH'(j));
    end
  end

  assign bus.sc_value = sc_q;
  assign bus.running  = (state_q == ST_RUNNING);
  assign bus.t_out    = t_dec;
  assign bus.d_out    = d_dec;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timing_sequencer
// Directed bench for timing_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_timing_sequencer;

  localparam int SC_WIDTH = 4;
  localparam int OP_WIDTH = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  timing_sequencer_if #(.SC_WIDTH(SC_WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

  timing_sequencer #(.SC_WIDTH(SC_WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.halt    = 1'b0;
    bus.sc_clr  = 1'b0;
    bus.sc_inc  = 1'b0;
    bus.op_load = 1'b0;
    bus.op_in   = '0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic inc_n(input int n);
    bus.sc_inc = 1'b1;
    for (int k = 0; k < n; k++) tick();
    bus.sc_inc = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.t_out !== 16'h0000) begin n_errors++; $display("FAIL reset_t_out: got %h exp %h", bus.t_out, 16'h0000); end
    n_checks++; if (bus.d_out !== 8'h01) begin n_errors++; $display("FAIL reset_d_out: got %h exp %h", bus.d_out, 8'h01); end
    n_checks++; if (bus.running !== 1'b0) begin n_errors++; $display("FAIL reset_running: got %b exp 0", bus.running); end
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL reset_sc: got %0d exp 0", bus.sc_value); end
    n_checks++; if (bus.wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap: got %b exp 0", bus.wrap); end
    // Strobes while stopped are ignored.
    bus.sc_inc = 1'b1;
    tick();
    bus.sc_inc = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL stopped_inc_ignored: got %0d exp 0", bus.sc_value); end
  endtask

  task automatic test_count();
    logic [15:0] exp_t [4];
    exp_t[0] = 16'h0001; exp_t[1] = 16'h0002; exp_t[2] = 16'h0004; exp_t[3] = 16'h0008;
    pulse_start();
    n_checks++; if (bus.running !== 1'b1) begin n_errors++; $display("FAIL count_running: got %b exp 1", bus.running); end
    n_checks++; if (bus.t_out !== exp_t[0]) begin n_errors++; $display("FAIL count_t0: got %h exp %h", bus.t_out, exp_t[0]); end
    bus.sc_inc = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (bus.t_out !== exp_t[k]) begin n_errors++; $display("FAIL count_t%0d: got %h exp %h", k, bus.t_out, exp_t[k]); end
    end
    bus.sc_inc = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd3) begin n_errors++; $display("FAIL count_sc: got %0d exp 3", bus.sc_value); end
  endtask

  task automatic test_clr_priority();
    inc_n(2);
    n_checks++; if (bus.sc_value !== 4'd5) begin n_errors++; $display("FAIL clr_setup_sc: got %0d exp 5", bus.sc_value); end
    bus.sc_clr = 1'b1;
    bus.sc_inc = 1'b1;
    tick();
    bus.sc_clr = 1'b0;
    bus.sc_inc = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL clr_beats_inc_sc: got %0d exp 0", bus.sc_value); end
    n_checks++; if (bus.t_out !== 16'h0001) begin n_errors++; $display("FAIL clr_beats_inc_t: got %h exp 0001", bus.t_out); end
  endtask

  task automatic test_wrap();
    inc_n(15);
    n_checks++; if (bus.t_out !== 16'h8000) begin n_errors++; $display("FAIL wrap_at_max_t: got %h exp 8000", bus.t_out); end
    n_checks++; if (bus.wrap !== 1'b0) begin n_errors++; $display("FAIL wrap_before: got %b exp 0", bus.wrap); end
    inc_n(1);
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL wrap_sc: got %0d exp 0", bus.sc_value); end
    n_checks++; if (bus.wrap !== 1'b1) begin n_errors++; $display("FAIL wrap_pulse: got %b exp 1", bus.wrap); end
    tick();
    n_checks++; if (bus.wrap !== 1'b0) begin n_errors++; $display("FAIL wrap_one_cycle: got %b exp 0", bus.wrap); end
    // sc_clr (with sc_inc) from max is not a wrap.
    inc_n(15);
    bus.sc_clr = 1'b1;
    bus.sc_inc = 1'b1;
    tick();
    bus.sc_clr = 1'b0;
    bus.sc_inc = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL clr_at_max_sc: got %0d exp 0", bus.sc_value); end
    n_checks++; if (bus.wrap !== 1'b0) begin n_errors++; $display("FAIL clr_at_max_wrap: got %b exp 0", bus.wrap); end
  endtask

  task automatic test_halt();
    inc_n(3);
    bus.sc_inc = 1'b1;
    bus.halt   = 1'b1;
    tick();
    bus.halt   = 1'b0;
    n_checks++; if (bus.running !== 1'b0) begin n_errors++; $display("FAIL halt_running: got %b exp 0", bus.running); end
    n_checks++; if (bus.t_out !== 16'h0000) begin n_errors++; $display("FAIL halt_t_out: got %h exp 0000", bus.t_out); end
    n_checks++; if (bus.sc_value !== 4'd3) begin n_errors++; $display("FAIL halt_sc: got %0d exp 3", bus.sc_value); end
    bus.sc_clr = 1'b1;
    tick();
    tick();
    bus.sc_clr = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd3) begin n_errors++; $display("FAIL halt_sc_holds: got %0d exp 3", bus.sc_value); end
    pulse_start();
    bus.sc_inc = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL restart_sc: got %0d exp 0", bus.sc_value); end
    n_checks++; if (bus.t_out !== 16'h0001) begin n_errors++; $display("FAIL restart_t: got %h exp 0001", bus.t_out); end
  endtask

  task automatic test_start_halt_op();
    inc_n(6);
    bus.start = 1'b1;
    bus.halt  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    n_checks++; if (bus.running !== 1'b0) begin n_errors++; $display("FAIL start_halt_running: got %b exp 0", bus.running); end
    n_checks++; if (bus.sc_value !== 4'd6) begin n_errors++; $display("FAIL start_halt_sc: got %0d exp 6", bus.sc_value); end
    pulse_start();
    inc_n(2);
    // start while running with sc_clr/sc_inc still restarts at 0.
    bus.start  = 1'b1;
    bus.sc_inc = 1'b1;
    tick();
    bus.start  = 1'b0;
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL start_overrides_inc: got %0d exp 0", bus.sc_value); end
    bus.op_load = 1'b1;
    bus.op_in   = 3'd5;
    #1;
    n_checks++; if (bus.d_out !== 8'h01) begin n_errors++; $display("FAIL op_before_edge: got %h exp 01", bus.d_out); end
    tick();
    bus.op_load = 1'b0;
    bus.sc_inc  = 1'b0;
    n_checks++; if (bus.d_out !== 8'h20) begin n_errors++; $display("FAIL op_load_d: got %h exp 20", bus.d_out); end
    n_checks++; if (bus.sc_value !== 4'd1) begin n_errors++; $display("FAIL op_load_same_edge_sc: got %0d exp 1", bus.sc_value); end
    bus.op_in = 'x;
    tick();
    tick();
    n_checks++; if (bus.d_out !== 8'h20) begin n_errors++; $display("FAIL op_no_load_x: got %h exp 20", bus.d_out); end
    bus.op_in = '0;
  endtask

  task automatic test_async_reset();
    pulse_start();
    bus.op_load = 1'b1;
    bus.op_in   = 3'd7;
    inc_n(9);
    bus.op_load = 1'b0;
    n_checks++; if (bus.t_out !== 16'h0200) begin n_errors++; $display("FAIL pre_reset_t: got %h exp 0200", bus.t_out); end
    n_checks++; if (bus.d_out !== 8'h80) begin n_errors++; $display("FAIL pre_reset_d: got %h exp 80", bus.d_out); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.t_out !== 16'h0000) begin n_errors++; $display("FAIL async_reset_t: got %h exp 0000", bus.t_out); end
    n_checks++; if (bus.d_out !== 8'h01) begin n_errors++; $display("FAIL async_reset_d: got %h exp 01", bus.d_out); end
    n_checks++; if (bus.sc_value !== 4'd0) begin n_errors++; $display("FAIL async_reset_sc: got %0d exp 0", bus.sc_value); end
    n_checks++; if (bus.running !== 1'b0) begin n_errors++; $display("FAIL async_reset_running: got %b exp 0", bus.running); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.running !== 1'b0) begin n_errors++; $display("FAIL no_resume: got %b exp 0", bus.running); end
    pulse_start();
    n_checks++; if (bus.t_out !== 16'h0001) begin n_errors++; $display("FAIL post_reset_t0: got %h exp 0001", bus.t_out); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_count();
    test_clr_priority();
    test_wrap();
    test_halt();
    test_start_halt_op();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
